// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory responder for the single-cycle core.
// It accepts one load/store per transaction, waits WAIT_CYCLES, then pulses
// ready_o for one cycle with registered read data.
// Optional feature macro: DMEM_ALIGN_CHECK_EN. When it is defined, a request
// with a nonzero byte offset raises err_o, has its store suppressed and reads
// back zero. When it is not defined, err_o is tied low.
module dmem_responder #(
   parameter int unsigned ADDR_WIDTH  = 8,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic        busy_o,
   output logic        ready_o,
   output logic [31:0] rdata_o,
   output logic        err_o
);

   localparam int unsigned DEPTH     = 1 << ADDR_WIDTH;
   localparam logic [3:0]  WAIT_LD   = 4'(WAIT_CYCLES);
   localparam bit          ZERO_WAIT = (WAIT_CYCLES == 0);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   // Only the word index and the byte offset are kept; the upper address
   // bits alias away.
   typedef struct packed {
      logic                  we;
      logic [ADDR_WIDTH-1:0] idx;
      logic [1:0]            ofs;
      logic [31:0]           wdata;
   } dmem_req_t;

   state_t      state;
   logic [3:0]  cnt;
   dmem_req_t   req_q;
   dmem_req_t   live_req;
   dmem_req_t   acc_req;
   logic        acc_go;
   logic        mem_we;
   logic [31:0] ld_data;
   logic [31:0] mem [DEPTH];

   assign live_req = {we_i, addr_i[ADDR_WIDTH+1:2], addr_i[1:0], wdata_i};

   // Upper address bits are ignored by design.
   logic unused_addr;
   assign unused_addr = ^addr_i[31:ADDR_WIDTH+2];

   // Choose the request that touches the array this edge. With zero wait
   // states the live inputs are used on the accept edge; otherwise the
   // captured request is used on the last WAIT edge.
   always_comb begin
      acc_go  = 1'b0;
      acc_req = req_q;
      if (state == S_IDLE && req_i && ZERO_WAIT) begin
         acc_go  = 1'b1;
         acc_req = live_req;
      end else if (state == S_WAIT && cnt == 4'd1) begin
         acc_go = 1'b1;
      end
   end

`ifdef DMEM_ALIGN_CHECK_EN
   logic acc_misal;
   logic err_q;

   assign acc_misal = (acc_req.ofs != 2'b00);
   assign mem_we    = acc_go & acc_req.we & ~acc_misal & ~rst_i;
   assign ld_data   = acc_misal ? 32'h0 : mem[acc_req.idx];
   assign err_o     = err_q;

   // The error flag is loaded on RESP entry and held until the next one.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)       err_q <= 1'b0;
      else if (acc_go) err_q <= acc_misal;
   end
`else
   logic unused_ofs;

   assign unused_ofs = ^acc_req.ofs;
   assign mem_we     = acc_go & acc_req.we & ~rst_i;
   assign ld_data    = mem[acc_req.idx];
   assign err_o      = 1'b0;
`endif

   // Storage array is not reset; a write happens only on RESP entry, so a
   // store dropped by reset while in WAIT never reaches the array.
   always_ff @(posedge clk_i) begin
      if (mem_we) mem[acc_req.idx] <= acc_req.wdata;
   end

   // Control FSM with registered handshake outputs and read data.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state   <= S_IDLE;
         cnt     <= 4'd0;
         busy_o  <= 1'b0;
         ready_o <= 1'b0;
         rdata_o <= 32'h0;
         req_q   <= '0;
      end else begin
         ready_o <= acc_go;
         if (acc_go) rdata_o <= acc_req.we ? 32'h0 : ld_data;
         case (state)
            S_IDLE: begin
               if (req_i) begin
                  req_q  <= live_req;
                  cnt    <= WAIT_LD;
                  busy_o <= 1'b1;
                  state  <= ZERO_WAIT ? S_RESP : S_WAIT;
               end
            end
            S_WAIT: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) state <= S_RESP;
            end
            S_RESP: begin
               busy_o <= 1'b0;
               state  <= S_IDLE;
            end
            default: begin
               busy_o <= 1'b0;
               state  <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder. Instance u_dut_a runs with two wait
// states, and instance u_dut_b runs with none. The expected values in the
// tables are worked out by hand.
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b0;

   logic        req_a = 1'b0, we_a = 1'b0;
   logic [31:0] addr_a = '0, wdata_a = '0;
   logic        busy_a, ready_a, err_a;
   logic [31:0] rdata_a;

   logic        req_b = 1'b0, we_b = 1'b0;
   logic [31:0] addr_b = '0, wdata_b = '0;
   logic        busy_b, ready_b, err_b;
   logic [31:0] rdata_b;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   dmem_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(2)) u_dut_a (
      .clk_i(clk), .rst_i(rst), .req_i(req_a), .we_i(we_a), .addr_i(addr_a),
      .wdata_i(wdata_a), .busy_o(busy_a), .ready_o(ready_a), .rdata_o(rdata_a),
      .err_o(err_a));

   dmem_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(0)) u_dut_b (
      .clk_i(clk), .rst_i(rst), .req_i(req_b), .we_i(we_b), .addr_i(addr_b),
      .wdata_i(wdata_b), .busy_o(busy_b), .ready_o(ready_b), .rdata_o(rdata_b),
      .err_o(err_b));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
      end
   endtask

   // One full transaction on u_dut_a, with its latency and response checked.
   task automatic txn_a(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp_rd,
                        input logic exp_err);
      int lat;
      lat = 0;
      @(negedge clk);
      req_a = 1'b1; we_a = we; addr_a = addr; wdata_a = wd;
      @(posedge clk);
      #1 req_a = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (i == 1) chk({tag, ".busy_after_accept"}, 32'(busy_a), 32'd1);
         if (ready_a) begin
            lat = i;
            break;
         end
      end
      chk({tag, ".latency"}, 32'(lat), 32'd3);
      chk({tag, ".rdata"}, rdata_a, exp_rd);
      chk({tag, ".err"}, 32'(err_a), 32'(exp_err));
      @(negedge clk);
      chk({tag, ".ready_drop"}, 32'(ready_a), 32'd0);
      chk({tag, ".busy_drop"}, 32'(busy_a), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] vals [3];
      vals[0] = 32'hA1B2C3D4;
      vals[1] = 32'h0F0F0F0F;
      vals[2] = 32'h13579BDF;

      // reset state
      #2 rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst.busy_a", 32'(busy_a), 32'd0);
      chk("rst.ready_a", 32'(ready_a), 32'd0);
      chk("rst.rdata_a", rdata_a, 32'd0);
      chk("rst.err_a", 32'(err_a), 32'd0);
      chk("rst.busy_b", 32'(busy_b), 32'd0);
      chk("rst.ready_b", 32'(ready_b), 32'd0);
      chk("rst.rdata_b", rdata_b, 32'd0);
      rst = 1'b0;

      // basic store/load with two wait states
      txn_a("st10", 1'b1, 32'h0000_0010, 32'hDEADBEEF, 32'h0, 1'b0);
      txn_a("ld10", 1'b0, 32'h0000_0010, 32'h0, 32'hDEADBEEF, 1'b0);

      // zero wait states, req held high, alternating store/load to 0x04
      @(negedge clk);
      req_b = 1'b1;
      for (int k = 0; k < 3; k++) begin
         we_b = 1'b1; addr_b = 32'h4; wdata_b = vals[k];
         @(negedge clk);
         chk("b.st.ready", 32'(ready_b), 32'd1);
         chk("b.st.busy", 32'(busy_b), 32'd1);
         chk("b.st.rdata", rdata_b, 32'd0);
         we_b = 1'b0;
         @(negedge clk);
         chk("b.idle.ready", 32'(ready_b), 32'd0);
         chk("b.idle.busy", 32'(busy_b), 32'd0);
         @(negedge clk);
         chk("b.ld.ready", 32'(ready_b), 32'd1);
         chk("b.ld.rdata", rdata_b, vals[k]);
         @(negedge clk);
         chk("b.idle2.ready", 32'(ready_b), 32'd0);
         chk("b.idle2.busy", 32'(busy_b), 32'd0);
      end
      req_b = 1'b0;

      // aliasing: 0x400 and 0x000 map to index 0 with ADDR_WIDTH=8
      txn_a("st400", 1'b1, 32'h0000_0400, 32'h12345678, 32'h0, 1'b0);
      txn_a("ld000", 1'b0, 32'h0000_0000, 32'h0, 32'h12345678, 1'b0);

      // reset during WAIT drops the pending store
      txn_a("st20", 1'b1, 32'h0000_0020, 32'h11111111, 32'h0, 1'b0);
      txn_a("ld20", 1'b0, 32'h0000_0020, 32'h0, 32'h11111111, 1'b0);
      @(negedge clk);
      req_a = 1'b1; we_a = 1'b1; addr_a = 32'h20; wdata_a = 32'hA5A5A5A5;
      @(posedge clk);
      #1 req_a = 1'b0;
      @(negedge clk);
      chk("rstw.busy_before", 32'(busy_a), 32'd1);
      rst = 1'b1;
      #1;
      chk("rstw.busy", 32'(busy_a), 32'd0);
      chk("rstw.ready", 32'(ready_a), 32'd0);
      chk("rstw.rdata", rdata_a, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      txn_a("ld20_after_rst", 1'b0, 32'h0000_0020, 32'h0, 32'h11111111, 1'b0);

`ifdef DMEM_ALIGN_CHECK_EN
      txn_a("st22_mis", 1'b1, 32'h0000_0022, 32'hCAFEF00D, 32'h0, 1'b1);
      txn_a("ld20_prior", 1'b0, 32'h0000_0020, 32'h0, 32'h11111111, 1'b0);
      txn_a("ld23_mis", 1'b0, 32'h0000_0023, 32'h0, 32'h0, 1'b1);
`else
      txn_a("st23", 1'b1, 32'h0000_0023, 32'hCAFEF00D, 32'h0, 1'b0);
      txn_a("ld20_new", 1'b0, 32'h0000_0020, 32'h0, 32'hCAFEF00D, 1'b0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder that answers the single-cycle core's load/store requests. It accepts one request per transaction over a req/ready handshake and inserts a programmable number of wait states. It holds a word-addressed storage array and returns registered read data. It sits between the datapath's memory-access outputs (address, store data, write enable) and its load-data input, and is the stall source for the memory stage.

## Interface
- `ADDR_WIDTH`, 8, word-index width; depth = 2**ADDR_WIDTH 32-bit words
- `WAIT_CYCLES`, 2, wait states inserted before the response (legal 0..15)

- `clk_i` in 1: sole clock, rising edge
- `rst_i` in 1: **asynchronous, active-high reset**
- `req_i` in 1: request valid; sampled only in IDLE
- `we_i` in 1: 1 = store, 0 = load
- `addr_i` in 32: byte address
- `wdata_i` in 32: store data
- `busy_o` out 1: high in WAIT and RESP; core must hold off new requests
- `ready_o` out 1: one-cycle response pulse
- `rdata_o` out 32: load data, valid while `ready_o`=1
- `err_o` out 1: misalignment flag, valid while `ready_o`=1 (see Configuration)

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE transitions:
  - `req_i`=1 → accept. Capture `we_i`, `addr_i`, `wdata_i`; load the wait counter with WAIT_CYCLES.
  - Next state is WAIT if WAIT_CYCLES>0, else RESP.
- WAIT: counter decrements each edge. On the edge where the counter reads 1, go to RESP.
- Array access occurs on the edge entering RESP, using the captured request. If WAIT_CYCLES=0, the live inputs are used on the accept edge.
  - Load: `rdata_o` <= mem[idx].
  - Store: mem[idx] <= wdata; `rdata_o` <= 0.
- RESP: `ready_o`=1 for exactly one cycle, then IDLE unconditionally. `req_i` is ignored in RESP; back-to-back requests are accepted from IDLE on the following edge.
- Word index idx = addr[ADDR_WIDTH+1:2]. Address bits above that are ignored, so addresses alias modulo 4·depth. The byte-offset bits addr[1:0] are ignored unless alignment checking is compiled in.
- Storage array is not reset; contents are undefined until written.
- `rdata_o` and `err_o` hold their value until the next RESP entry.

## Timing
- Reset values: state IDLE, `busy_o`=0, `ready_o`=0, `rdata_o`=0, `err_o`=0, counter 0.
- Latency: call the accept edge edge 1. `ready_o` is high in the cycle after edge WAIT_CYCLES+1.
  - WAIT_CYCLES=2 → ready in cycle 3 after accept.
  - WAIT_CYCLES=0 → ready in the cycle right after accept.
- `busy_o` rises in the cycle after the accept edge and falls together with `ready_o`.
- Throughput: one transaction per WAIT_CYCLES+2 cycles with `req_i` held high.
- `req_i` held high through RESP does not create a second transaction until IDLE samples it.
- A load issued after a store to the same index returns the new data. No hazard exists because transactions are serialized.
- Reset mid-transaction (WAIT or RESP): immediately return to IDLE with all outputs at reset values.
  - A store still in WAIT is dropped, and the array is unchanged.
  - A store already committed on RESP entry is kept.

## Configuration
- `DMEM_ALIGN_CHECK_EN` defined:
  - If captured addr[1:0] ≠ 0, the store is suppressed and a load returns 0.
  - `err_o`=1 during that response's RESP cycle; otherwise `err_o`=0.
  - The handshake and latency are unchanged.
- Not defined:
  - addr[1:0] is ignored.
  - `err_o` is tied to 0.
  - No alignment logic is present.

## Test plan
- Reset, then store 0xDEADBEEF to 0x0000_0010 and load from 0x10 with WAIT_CYCLES=2 → each `ready_o` pulse occurs exactly 3 cycles after accept; load `rdata_o`=0xDEADBEEF; store `rdata_o`=0.
- WAIT_CYCLES=0, alternating store/load to 0x04 with `req_i` held high → ready every 2nd cycle; loaded value equals the value just stored; `busy_o`=0 only in IDLE cycles.
- Aliasing with ADDR_WIDTH=8: store 0x12345678 to 0x0000_0400, then load 0x0000_0000 → 0x12345678.
- Assert `rst_i` for one cycle in WAIT of a store of 0xA5A5A5A5 to 0x20, after first storing 0x11111111 there → outputs go to 0 asynchronously; a subsequent load of 0x20 returns 0x11111111.
- With `DMEM_ALIGN_CHECK_EN` defined: store 0xCAFEF00D to 0x22 → `err_o`=1 on ready; a load from 0x20 returns the prior contents. A load from 0x23 → `err_o`=1 and `rdata_o`=0.
- Without `DMEM_ALIGN_CHECK_EN`: store 0xCAFEF00D to 0x23 → `err_o`=0; a load from 0x20 returns 0xCAFEF00D.
